// File: rtl/mem_responder_if.sv
// Request/response bus for mem_responder.
//   req   : request strobe, sampled on the rising clock edge
//   wr    : 1 = write, 0 = read, sampled with req
//   addr  : byte address, sampled with req
//   wdata : write data, sampled with req
//   rdata : registered read data
//   busy  : a request is outstanding
//   done  : one-cycle completion pulse
//   err   : failed access, meaningful only while done is high
interface mem_responder_if;
    logic        req;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output req, wr, addr, wdata,
        input  rdata, busy, done, err
    );

    modport slave (
        input  req, wr, addr, wdata,
        output rdata, busy, done, err
    );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency word memory responder.
// A request is accepted in IDLE or RESP, waits LATENCY clock edges in WAIT,
// then completes in RESP with a one-cycle done pulse. Storage is DEPTH_WORDS
// 32-bit words addressed by addr[31:2]; misaligned or out-of-range accesses
// complete with err=1 and have no side effects.
// Ports:
//   clk   : clock, rising edge active
//   reset : asynchronous active-low reset; clears state, storage and outputs
//   bus   : mem_responder_if slave modport (req/wr/addr/wdata in,
//           rdata/busy/done/err out, all outputs registered)
module mem_responder #(
    parameter int LATENCY     = 3,
    parameter int DEPTH_WORDS = 64
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_q;
    logic [2:0]         cnt_q;
    logic               wr_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic [31:0]        mem_q [DEPTH_WORDS];

    logic               valid_s;
    logic [IDX_W-1:0]   idx_s;

    // Decode the captured address into a word index and a validity flag.
    always_comb begin
        valid_s = (addr_q[1:0] == 2'b00) &&
                  ({2'b00, addr_q[31:2]} < 32'(DEPTH_WORDS));
        idx_s   = addr_q[IDX_W+1:2];
    end

    // Request FSM, storage and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            wr_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else begin
            case (state_q)
                // RESP accepts just like IDLE so requests can run back-to-back.
                ST_IDLE, ST_RESP: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (bus.req) begin
                        wr_q    <= bus.wr;
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        cnt_q   <= 3'(LATENCY - 1);
                        busy_q  <= 1'b1;
                        state_q <= ST_WAIT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                // req is ignored here; the captured fields stay frozen.
                ST_WAIT: begin
                    if (cnt_q == 3'd0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= ~valid_s;
                        state_q <= ST_RESP;
                        if (valid_s) begin
                            if (wr_q) begin
                                mem_q[idx_s] <= wdata_q;
                            end else begin
                                rdata_q <= mem_q[idx_s];
                            end
                        end else begin
                            rdata_q <= rdata_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    cnt_q   <= 3'd0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int LAT   = 3;
    localparam int DEPTH = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    bit   cmp_en = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    mem_responder_if bus ();

    mem_responder #(
        .LATENCY     (LAT),
        .DEPTH_WORDS (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // phase: 0 idle, 1 request in flight, 2 completion cycle
    int          m_phase;
    int          m_left;
    bit          m_wr;
    logic [31:0] m_addr, m_wdata, m_rdata;
    bit          m_err;
    logic [31:0] m_mem [DEPTH];

    function automatic bit addr_ok(input logic [31:0] a);
        return (a % 4 == 0) && ((a / 4) < DEPTH);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_left  <= 0;
            m_err   <= 1'b0;
            m_rdata <= 32'd0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] <= 32'd0;
        end else if (m_phase == 1) begin
            // edges remaining until completion; the last one performs the access
            if (m_left == 1) begin
                m_phase <= 2;
                m_err   <= !addr_ok(m_addr);
                if (addr_ok(m_addr)) begin
                    if (m_wr) m_mem[m_addr / 4] <= m_wdata;
                    else      m_rdata <= m_mem[m_addr / 4];
                end
            end
            m_left <= m_left - 1;
        end else if (bus.req) begin
            m_phase <= 1;
            m_left  <= LAT;
            m_wr    <= bus.wr;
            m_addr  <= bus.addr;
            m_wdata <= bus.wdata;
            m_err   <= 1'b0;
        end else begin
            m_phase <= 0;
            m_err   <= 1'b0;
        end
    end

    // Compare process: every cycle against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy",  {31'd0, bus.busy},  {31'd0, (m_phase == 1)});
            chk("done",  {31'd0, bus.done},  {31'd0, (m_phase == 2)});
            chk("err",   {31'd0, bus.err},   {31'd0, (m_phase == 2) && m_err});
            chk("rdata", bus.rdata, m_rdata);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.req = 1'b1; bus.wr = w; bus.addr = a; bus.wdata = d;
        @(negedge clk);
        bus.req = 1'b0;
    endtask

    // Called at the negedge right after the accepting edge.
    task automatic wait_done(output int edges, output int nbusy);
        edges = 0;
        nbusy = 0;
        while (!bus.done && edges < 20) begin
            if (bus.busy) nbusy++;
            @(negedge clk);
            edges++;
        end
    endtask

    int edges, nbusy, extra;

    initial begin
        bus.req = 1'b0; bus.wr = 1'b0; bus.addr = 32'd0; bus.wdata = 32'd0;
        #1 cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_rdata", bus.rdata, 32'd0);
        chk("reset_busy",  {31'd0, bus.busy}, 32'd0);
        chk("reset_done",  {31'd0, bus.done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // write 0xDEADBEEF to 0x10
        issue(1'b1, 32'h10, 32'hDEADBEEF);
        wait_done(edges, nbusy);
        chk("wr_latency", edges, 32'd3);
        chk("wr_busy_cycles", nbusy, 32'd3);
        chk("wr_err", {31'd0, bus.err}, 32'd0);
        chk("wr_rdata", bus.rdata, 32'd0);
        @(negedge clk);

        // read back 0x10
        issue(1'b0, 32'h10, 32'd0);
        wait_done(edges, nbusy);
        chk("rd_latency", edges, 32'd3);
        chk("rd_rdata", bus.rdata, 32'hDEADBEEF);
        chk("rd_err", {31'd0, bus.err}, 32'd0);
        @(negedge clk);

        // back-to-back: write 0x04, req held through RESP with a read of 0x04
        bus.req = 1'b1; bus.wr = 1'b1; bus.addr = 32'h04; bus.wdata = 32'h12345678;
        @(negedge clk);
        bus.wr = 1'b0; bus.wdata = 32'd0;
        wait_done(edges, nbusy);
        chk("b2b_wr_latency", edges, 32'd3);
        @(negedge clk);
        bus.req = 1'b0;
        chk("b2b_accept_busy", {31'd0, bus.busy}, 32'd1);
        chk("b2b_accept_done", {31'd0, bus.done}, 32'd0);
        wait_done(edges, nbusy);
        chk("b2b_rd_latency", edges, 32'd3);
        chk("b2b_rd_rdata", bus.rdata, 32'h12345678);
        @(negedge clk);

        // invalid accesses: misaligned read, out-of-range write
        issue(1'b0, 32'h02, 32'd0);
        wait_done(edges, nbusy);
        chk("mis_err", {31'd0, bus.err}, 32'd1);
        chk("mis_rdata", bus.rdata, 32'h12345678);
        @(negedge clk);
        issue(1'b1, 32'h100, 32'hBAD0BAD0);
        wait_done(edges, nbusy);
        chk("oor_err", {31'd0, bus.err}, 32'd1);
        @(negedge clk);
        issue(1'b0, 32'h00, 32'd0);
        wait_done(edges, nbusy);
        chk("oor_no_alias", bus.rdata, 32'd0);
        @(negedge clk);

        // reset in the middle of a write
        issue(1'b1, 32'h08, 32'hCAFEF00D);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy_drop", {31'd0, bus.busy}, 32'd0);
        chk("rst_no_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done) extra++;
        end
        chk("rst_no_done_after", extra, 32'd0);
        issue(1'b0, 32'h08, 32'd0);
        wait_done(edges, nbusy);
        chk("rst_no_commit", bus.rdata, 32'd0);
        @(negedge clk);

        // req pulsed while waiting is ignored
        issue(1'b1, 32'h0C, 32'h0000A5A5);
        bus.req = 1'b1; bus.wr = 1'b1; bus.addr = 32'h0C; bus.wdata = 32'hFFFFFFFF;
        @(negedge clk);
        bus.req = 1'b0;
        wait_done(edges, nbusy);
        chk("ign_latency", edges, 32'd2);
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) extra++;
        end
        chk("ign_single_done", extra, 32'd0);
        issue(1'b0, 32'h0C, 32'd0);
        wait_done(edges, nbusy);
        chk("ign_rdata", bus.rdata, 32'h0000A5A5);
        @(negedge clk);

        // randomized traffic, checked by the model every cycle
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            int r;
            if (i == 300) begin
                #3 rst_n = 1'b0;
            end
            if (i == 302) rst_n = 1'b1;
            r = $urandom_range(0, 9);
            a = 32'($urandom_range(0, 15)) << 2;
            if (r == 0) a = a | 32'($urandom_range(1, 3));
            if (r == 1) a = 32'(DEPTH + $urandom_range(0, 200)) << 2;
            if (r == 2) a = $urandom;
            bus.req   = ($urandom_range(0, 1) == 1);
            bus.wr    = ($urandom_range(0, 1) == 1);
            bus.addr  = a;
            bus.wdata = $urandom;
            @(negedge clk);
        end
        bus.req = 1'b0;
        repeat (12) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter LATENCY, default 3, SHALL set the number of clock edges from request acceptance to response; legal range is 1..7.
REQ-002 Parameter DEPTH_WORDS, default 64, SHALL set the number of 32-bit storage words; legal range is 1..256.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req  input  1  SHALL be the request strobe, sampled on the rising edge.
REQ-006 wr  input  1  SHALL select the operation: 1 = write, 0 = read; sampled with req.
REQ-007 addr  input  32  SHALL be the byte address, sampled with req.
REQ-008 wdata  input  32  SHALL be the write data, sampled with req.
REQ-009 rdata  output  32  SHALL be the registered read data.
REQ-010 busy  output  1  SHALL be high while a request is outstanding (state WAIT).
REQ-011 done  output  1  SHALL be a one-cycle completion pulse (state RESP).
REQ-012 err  output  1  SHALL flag a failed access; valid only while done=1.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-014 IDLE or RESP with req=1 at an edge SHALL accept the request:
- capture wr, addr and wdata;
- load the 3-bit counter with LATENCY-1;
- go to WAIT.
REQ-015 IDLE with req=0 SHALL stay in IDLE; RESP with req=0 SHALL go to IDLE.
REQ-016 In WAIT, an edge with counter=0 SHALL go to RESP; otherwise the counter SHALL decrement and the FSM SHALL stay in WAIT.
REQ-017 done SHALL therefore rise exactly LATENCY edges after the accepting edge and stay high for one cycle.
REQ-018 req SHALL be ignored in WAIT; captured fields SHALL not change while busy.
REQ-019 A request accepted in RESP SHALL give back-to-back operation: done is high for one cycle, then busy is high in the next cycle.
REQ-020 Word index SHALL be addr[31:2]; an access is invalid if addr[1:0]≠0 or addr[31:2]≥DEPTH_WORDS.
REQ-021 A valid write SHALL update the addressed word on the WAIT→RESP edge; rdata SHALL be unchanged.
REQ-022 A valid read SHALL load rdata with the addressed word on the WAIT→RESP edge.
REQ-023 rdata SHALL hold its value until the next valid read completes.
REQ-024 An invalid access SHALL not modify storage or rdata and SHALL drive err=1 during its RESP cycle.
REQ-025 err SHALL be 0 whenever done=0.
REQ-026 A write followed by a read of the same word SHALL return the new data, including when the two are back-to-back.
REQ-027 busy and done SHALL never be high at the same time.

Reset
REQ-028 reset=0 SHALL immediately, without waiting for a clock edge:
- force the FSM to IDLE and the counter to 0;
- clear every storage word to 0;
- drive rdata=0, busy=0, done=0 and err=0.
REQ-029 reset asserted mid-operation SHALL abort the request: no write commits and no done pulse is issued.
REQ-030 The first request SHALL be accepted on the first rising edge at which reset=1 and req=1.

Verification
REQ-031 Reset, then write 0xDEADBEEF to addr 0x10 (LATENCY=3) -> busy=1 for 3 cycles, done=1 for 1 cycle, err=0, rdata stays 0.
REQ-032 Read addr 0x10 after REQ-031 -> done exactly 3 edges after acceptance, rdata=0xDEADBEEF, err=0.
REQ-033 Write 0x12345678 to 0x04, with req held high through RESP, then read 0x04 -> second request accepted in the RESP cycle; next done gives rdata=0x12345678.
REQ-034 Read addr 0x02, then write to addr 0x100 (DEPTH_WORDS=64) -> err=1 with each done; storage and rdata unchanged.
REQ-035 reset=0 pulsed one cycle after a write to 0x08 is accepted -> busy drops immediately, no done pulse; a following read of 0x08 returns 0.
REQ-036 Pulse req during WAIT -> pulse ignored: exactly one done and only the first request's effect.
